// File: rtl/ps2_host_rx.sv
// rtl/ps2_host_rx.sv - PS/2 host receiver with input filtering, frame FSM and show-ahead byte FIFO
//
// ps2_rx_fifo: show-ahead byte FIFO of 2**BITS entries.
//   push/push_data  write request and byte
//   pop_req         pop request, ignored while empty
//   head            entry at the read pointer (0 while empty)
//   not_empty       FIFO holds at least one entry
//   count           entries held, 0..2**BITS
//   dropped         push refused because the FIFO was full with no pop
//
// ps2_host_rx: deserialises 11-bit PS/2 frames and queues good bytes.
//   clk, reset              system clock, asynchronous active-high reset
//   ps2_clk_in/ps2_data_in  PS/2 pair, asynchronous to clk
//   rx_data/rx_valid        FIFO head byte and non-empty flag
//   rx_read                 pop request
//   fifo_count              entries held
//   parity_err/frame_err    sticky frame error flags
//   overflow                sticky, good byte lost to a full FIFO
//   err_clear               clears the sticky flags

module ps2_rx_fifo #(
  parameter int BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_req,
  output logic [7:0]    head,
  output logic          not_empty,
  output logic [BITS:0] count,
  output logic          dropped
);

  localparam int DEPTH = 1 << BITS;

  logic [7:0]      mem [DEPTH];
  logic [BITS-1:0] wr_ptr;
  logic [BITS-1:0] rd_ptr;
  logic            full;
  logic            pop;
  logic            wr;

  assign not_empty = (count != '0);
  assign full      = (count == (BITS+1)'(DEPTH));
  assign pop       = pop_req & not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr        = push & (~full | pop);
  assign dropped   = push & full & ~pop;
  assign head      = not_empty ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module ps2_host_rx #(
  parameter int          FIFO_BITS = 3,
  parameter int          FILTER    = 4,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2_clk_in,
  input  logic                 ps2_data_in,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_read,
  output logic [FIFO_BITS:0]   fifo_count,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 err_clear
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Two-stage synchronisers; idle PS/2 lines are high, so reset to 1.
  logic clk_meta;
  logic clk_sync;
  logic dat_meta;
  logic dat_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      dat_meta <= ps2_data_in;
      dat_sync <= dat_meta;
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER consecutive cycles of disagreement.
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          flt_done;
  logic          fall;

  assign flt_done = (clk_sync != clk_filt) && (flt_cnt == FW'(FILTER - 1));
  // The cycle in which the filtered clock is about to drop 1->0.
  assign fall     = flt_done & clk_filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flt_done) begin
      clk_filt <= clk_sync;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  // Frame FSM
  state_t      state;
  state_t      state_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shreg;
  logic [7:0]  shreg_d;
  logic        par_acc;
  logic        par_d;
  logic [15:0] tmo_cnt;
  logic        timed_out;
  logic        push;
  logic        set_perr;
  logic        set_ferr;
  logic        fifo_drop;

  assign timed_out = (state != IDLE) && (tmo_cnt == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
    end else begin
      state   <= state_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      par_acc <= par_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    par_d     = par_acc;
    push      = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (timed_out) begin
      // Abandon the partial frame; the shift register is simply never pushed.
      state_d  = IDLE;
      set_ferr = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_sync) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            par_d     = 1'b0;
          end
        end
        DATA: begin
          // LSB arrives first, so shifting in from the top leaves it in bit 0.
          shreg_d   = {dat_sync, shreg[7:1]};
          par_d     = par_acc ^ dat_sync;
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = par_acc ^ dat_sync;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_sync) begin
            set_ferr = 1'b1;
          end else if (par_acc) begin
            push = 1'b1;
          end else begin
            set_perr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Inactivity counter; saturates at TIMEOUT, cleared by edges and in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || fall) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TIMEOUT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  ps2_rx_fifo #(
    .BITS(FIFO_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop_req   (rx_read),
    .head      (rx_data),
    .not_empty (rx_valid),
    .count     (fifo_count),
    .dropped   (fifo_drop)
  );

  // Sticky flags: a set condition wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (set_perr) begin
        parity_err <= 1'b1;
      end else if (err_clear) begin
        parity_err <= 1'b0;
      end
      if (set_ferr) begin
        frame_err <= 1'b1;
      end else if (err_clear) begin
        frame_err <= 1'b0;
      end
      if (fifo_drop) begin
        overflow <= 1'b1;
      end else if (err_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb/tb_ps2_host_rx.sv - self-checking bench for ps2_host_rx with a queue-based reference model

module tb_ps2_host_rx;

  localparam int          FB    = 3;
  localparam int          FLT   = 4;
  localparam logic [15:0] TMO   = 16'd1000;
  localparam int          DEPTH = 1 << FB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ps2_clk_in = 1'b1;
  logic          ps2_data_in = 1'b1;
  logic          rx_read = 1'b0;
  logic          err_clear = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [FB:0]   fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  ps2_host_rx #(
    .FIFO_BITS(FB),
    .FILTER(FLT),
    .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_read     (rx_read),
    .fifo_count  (fifo_count),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: bytes held, and the three sticky flags.
  logic [7:0] q[$];
  bit m_perr = 1'b0;
  bit m_ferr = 1'b0;
  bit m_ovf = 1'b0;
  bit chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Outcome of one complete frame whose start bit was 0.
  function automatic void model_frame(input logic [7:0] b, input logic p, input logic s);
    if (!s) begin
      m_ferr = 1'b1;
    end else if ((^b ^ p) == 1'b0) begin
      m_perr = 1'b1;
    end else if (q.size() < DEPTH) begin
      q.push_back(b);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk && !reset) begin
      check("valid", rx_valid, q.size() != 0);
      check("count", fifo_count, q.size());
      if (q.size() != 0) begin
        check("data", rx_data, q[0]);
      end
      check("parity_err", parity_err, m_perr);
      check("frame_err", frame_err, m_ferr);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives bits[0..nbits-1], data set while clock high, then a low phase.
  // With pop_last, rx_read is raised for exactly the cycle in which the last
  // bit is sampled: 2 synchroniser stages plus FILTER agreeing cycles.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int h, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = bits[i];
      wait_cyc(h);
      ps2_clk_in = 1'b0;
      if (pop_last && i == nbits - 1) begin
        wait_cyc(1 + FLT);
        rx_read = 1'b1;
        wait_cyc(1);
        rx_read = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        wait_cyc(h - 2 - FLT);
      end else begin
        wait_cyc(h);
      end
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic p, input logic s, input int h, input bit pop_last);
    chk = 1'b0;
    send_bits({s, p, b, 1'b0}, 11, h, pop_last);
    wait_cyc(h);
    model_frame(b, p, s);
    chk = 1'b1;
  endtask

  task automatic ctl(input bit rd, input bit clr);
    rx_read = rd;
    err_clear = clr;
    @(posedge clk);
    if (rd && q.size() > 0) void'(q.pop_front());
    if (clr) begin
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
    end
    #1;
    rx_read = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    logic [7:0] exp_seq [8];
    logic [7:0] b;
    logic       p;
    logic       s;
    int         kind;
    int         h;
    int         nops;

    wait_cyc(3);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cyc(2);
    chk = 1'b1;

    // Single good frame 0x1C, then one read
    frame(8'h1C, 1'b0, 1'b1, 20, 1'b0);
    check("t1_data", rx_data, 8'h1C);
    check("t1_valid", rx_valid, 1);
    check("t1_count", fifo_count, 1);
    ctl(1'b1, 1'b0);
    check("t1_empty", rx_valid, 0);
    check("t1_count0", fifo_count, 0);

    // Bad parity
    frame(8'h1C, 1'b1, 1'b1, 20, 1'b0);
    check("t2_perr", parity_err, 1);
    check("t2_count", fifo_count, 0);
    ctl(1'b0, 1'b1);
    check("t2_clear", parity_err, 0);

    // Bad stop bit
    frame(8'h33, odd_par(8'h33), 1'b0, 15, 1'b0);
    check("t3_ferr", frame_err, 1);
    check("t3_count", fifo_count, 0);
    ctl(1'b0, 1'b1);

    // Start plus three data bits, then the clock stalls high
    chk = 1'b0;
    send_bits(11'h00A, 4, 15, 1'b0);
    wait_cyc(TMO + 10);
    m_ferr = 1'b1;
    chk = 1'b1;
    check("t4_ferr", frame_err, 1);
    check("t4_count", fifo_count, 0);
    ctl(1'b0, 1'b1);
    frame(8'hF0, odd_par(8'hF0), 1'b1, 15, 1'b0);
    check("t4_data", rx_data, 8'hF0);
    check("t4_noerr", frame_err, 0);
    ctl(1'b1, 1'b0);

    // Fill past capacity with no reads
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      frame(b, odd_par(b), 1'b1, 10, 1'b0);
    end
    check("t5_count", fifo_count, 8);
    check("t5_ovf", overflow, 1);
    check("t5_head", rx_data, 8'h01);
    ctl(1'b0, 1'b1);
    // Frame lands on a full FIFO in the same cycle as a pop
    frame(8'h0A, odd_par(8'h0A), 1'b1, 10, 1'b1);
    check("t5_same_count", fifo_count, 8);
    check("t5_same_ovf", overflow, 0);
    check("t5_same_head", rx_data, 8'h02);
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 8; i++) begin
      check("t5_order", rx_data, exp_seq[i]);
      ctl(1'b1, 1'b0);
    end
    check("t5_drained", fifo_count, 0);
    ctl(1'b1, 1'b0);
    check("t5_empty_read", fifo_count, 0);

    // Two-cycle clock glitches with data low must not start a frame
    ps2_data_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk_in = 1'b0;
      wait_cyc(2);
      ps2_clk_in = 1'b1;
      wait_cyc(10);
    end
    wait_cyc(TMO + 20);
    check("t6_ferr", frame_err, 0);
    check("t6_perr", parity_err, 0);
    ps2_data_in = 1'b1;
    wait_cyc(10);
    frame(8'h3C, odd_par(8'h3C), 1'b1, 12, 1'b0);
    check("t6_data", rx_data, 8'h3C);

    // Reset in the middle of a frame, with data queued and a flag set
    frame(8'h77, 1'b0, 1'b1, 12, 1'b0);
    check("t7_pre_perr", parity_err, 1);
    chk = 1'b0;
    send_bits({1'b1, odd_par(8'h5A), 8'h5A, 1'b0}, 5, 12, 1'b0);
    reset = 1'b1;
    q.delete();
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    wait_cyc(2);
    check_all_zero("t7_reset");
    reset = 1'b0;
    wait_cyc(5);
    chk = 1'b1;
    frame(8'h5A, odd_par(8'h5A), 1'b1, 12, 1'b0);
    check("t7_data", rx_data, 8'h5A);
    check("t7_count", fifo_count, 1);
    ctl(1'b1, 1'b0);

    // Randomised traffic: mostly good frames, some bad, random reads/clears
    for (int n = 0; n < 50; n++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      h = $urandom_range(8, 20);
      p = odd_par(b);
      s = 1'b1;
      if (kind == 8) p = ~p;
      if (kind == 9) s = 1'b0;
      frame(b, p, s, h, ($urandom_range(0, 4) == 0));
      nops = $urandom_range(0, 3);
      for (int k = 0; k < nops; k++) begin
        ctl($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      end
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      ctl(1'b1, 1'b0);
    end
    check("end_count", fifo_count, 0);
    wait_cyc(3);
    chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
